// File: rtl/execute_stage_pkg.sv
// rtl/execute_stage_pkg.sv - shared constants for the RV32I execute stage
package execute_stage_pkg;

    localparam int XLEN = 32;

    // ALU operation codes (alucontrol)
    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;
    localparam logic [2:0] ALU_XOR  = 3'b100;
    localparam logic [2:0] ALU_SLT  = 3'b101;
    localparam logic [2:0] ALU_SLTU = 3'b110;

    // Forwarding selects from the hazard unit; 2'b11 behaves as FWD_RF
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // Writeback source selects
    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

endpackage

// File: rtl/execute_stage_alu.sv
// rtl/execute_stage_alu.sv - combinational ALU for the execute stage
// Ports: srcA, srcB (operands), alucontrol (op code) -> result, zero (result == 0)
module execute_stage_alu #(
    parameter int XLEN = execute_stage_pkg::XLEN
) (
    input  logic [XLEN-1:0] srcA,
    input  logic [XLEN-1:0] srcB,
    input  logic [2:0]      alucontrol,
    output logic [XLEN-1:0] result,
    output logic            zero
);
    import execute_stage_pkg::*;

    logic ltSigned;
    logic ltUnsigned;

    assign ltSigned   = $signed(srcA) < $signed(srcB);
    assign ltUnsigned = srcA < srcB;

    always_comb begin
        result = '0;
        case (alucontrol)
            ALU_ADD:  result = srcA + srcB;
            ALU_SUB:  result = srcA - srcB;
            ALU_AND:  result = srcA & srcB;
            ALU_OR:   result = srcA | srcB;
            ALU_XOR:  result = srcA ^ srcB;
            ALU_SLT:  result = {{(XLEN-1){1'b0}}, ltSigned};
            ALU_SLTU: result = {{(XLEN-1){1'b0}}, ltUnsigned};
            default:  result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/execute_stage.sv
// rtl/execute_stage.sv - EX stage: forwarding, ALU, branch resolve, EX/MEM register
// Ports: clk, rst (async active-low); E-side controls/data from decode;
//        forwardAE/forwardBE + resultW from hazard/writeback;
//        pcsrcE/pctargetE combinational to fetch; *M registered to memory stage.
module execute_stage #(
    parameter int XLEN    = execute_stage_pkg::XLEN,
    parameter int REGADDR = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               regwriteE,
    input  logic [1:0]         resultsrcE,
    input  logic               memwriteE,
    input  logic               jumpE,
    input  logic               branchE,
    input  logic [2:0]         alucontrolE,
    input  logic               alusrcE,
    input  logic [XLEN-1:0]    Rd1E,
    input  logic [XLEN-1:0]    Rd2E,
    input  logic [XLEN-1:0]    pcE,
    input  logic [XLEN-1:0]    ImmextE,
    input  logic [XLEN-1:0]    pcplus4E,
    input  logic [REGADDR-1:0] RdE,
    input  logic [1:0]         forwardAE,
    input  logic [1:0]         forwardBE,
    input  logic [XLEN-1:0]    resultW,
    output logic               pcsrcE,
    output logic [XLEN-1:0]    pctargetE,
    output logic               regwriteM,
    output logic [1:0]         resultsrcM,
    output logic               memwriteM,
    output logic [XLEN-1:0]    aluresultM,
    output logic [XLEN-1:0]    writedataM,
    output logic [REGADDR-1:0] RdM,
    output logic [XLEN-1:0]    pcplus4M
);
    import execute_stage_pkg::*;

    logic [XLEN-1:0] srcAE;
    logic [XLEN-1:0] srcBE;
    logic [XLEN-1:0] writedataE;
    logic [XLEN-1:0] aluresultE;
    logic            zeroE;

    // aluresultM is a register output, so feeding it back here forms no loop
    always_comb begin
        srcAE = Rd1E;
        case (forwardAE)
            FWD_WB:  srcAE = resultW;
            FWD_MEM: srcAE = aluresultM;
            default: srcAE = Rd1E;
        endcase
    end

    always_comb begin
        writedataE = Rd2E;
        case (forwardBE)
            FWD_WB:  writedataE = resultW;
            FWD_MEM: writedataE = aluresultM;
            default: writedataE = Rd2E;
        endcase
    end

    assign srcBE = alusrcE ? ImmextE : writedataE;

    execute_stage_alu #(.XLEN(XLEN)) u_alu (
        .srcA       (srcAE),
        .srcB       (srcBE),
        .alucontrol (alucontrolE),
        .result     (aluresultE),
        .zero       (zeroE)
    );

    assign pctargetE = pcE + ImmextE;
    assign pcsrcE    = (branchE & zeroE) | jumpE;

    // Store data is the forwarded rs2, never the immediate
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            regwriteM  <= 1'b0;
            resultsrcM <= '0;
            memwriteM  <= 1'b0;
            aluresultM <= '0;
            writedataM <= '0;
            RdM        <= '0;
            pcplus4M   <= '0;
        end else begin
            regwriteM  <= regwriteE;
            resultsrcM <= resultsrcE;
            memwriteM  <= memwriteE;
            aluresultM <= aluresultE;
            writedataM <= writedataE;
            RdM        <= RdE;
            pcplus4M   <= pcplus4E;
        end
    end

endmodule
